// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer for the EX stage; owns HI/LO and
// holds the pipeline while a MULT(U)/DIV(U) runs for DATA_WIDTH cycles.
//
// state  | meaning
// IDLE   | waiting for an accepted start; MTHI/MTLO only
// MUL    | shift-add iteration, counter counts down to 0
// DIV    | restoring shift-subtract iteration, counter counts down to 0
// DONE   | result visible on hi/lo, stall released for one cycle
module muldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  input  logic                  hilo_write_en,
  input  logic                  hilo_write_sel,
  input  logic [DATA_WIDTH-1:0] hilo_write_data,
  output logic                  stall_request,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   mcand;   // multiplicand or divisor
  logic [DATA_WIDTH-1:0]   acc_hi;  // product upper half or partial remainder
  logic [DATA_WIDTH-1:0]   acc_lo;  // multiplier/product lower half or dividend/quotient
  logic                    neg_q, neg_r;

  logic                    start_ok, div_by_zero, last_iter;
  logic                    sign_1, sign_2;
  logic [DATA_WIDTH-1:0]   abs_1, abs_2;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [DATA_WIDTH:0]     rem_shift;
  logic [DATA_WIDTH+1:0]   trial;
  logic [DATA_WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*DATA_WIDTH-1:0] product, product_fix;
  logic [DATA_WIDTH-1:0]   quo_fix, rem_fix;

  assign start_ok    = start & ~flush;
  assign div_by_zero = (operand_2 == '0);
  assign last_iter   = (cnt == '0);

  assign sign_1 = op[0] & operand_1[DATA_WIDTH-1];
  assign sign_2 = op[0] & operand_2[DATA_WIDTH-1];
  assign abs_1  = sign_1 ? -operand_1 : operand_1;
  assign abs_2  = sign_2 ? -operand_2 : operand_2;

  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = mul_sum[DATA_WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};

  // Restoring divide: a negative trial difference leaves the shifted remainder as is.
  assign rem_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, mcand};

  always_comb begin
    rem_nxt = rem_shift[DATA_WIDTH-1:0];
    quo_nxt = {acc_lo[DATA_WIDTH-2:0], 1'b0};
    if (!trial[DATA_WIDTH+1]) begin
      rem_nxt = trial[DATA_WIDTH-1:0];
      quo_nxt = {acc_lo[DATA_WIDTH-2:0], 1'b1};
    end
  end

  assign product     = {mul_hi_nxt, mul_lo_nxt};
  assign product_fix = neg_q ? -product : product;
  assign quo_fix     = neg_q ? -quo_nxt : quo_nxt;
  assign rem_fix     = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stall_request = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        stall_request = start_ok;
        if (start_ok) begin
          if (!op[1])          state_nxt = S_MUL;
          else if (div_by_zero) state_nxt = S_DONE;
          else                 state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        stall_request = 1'b1;
        busy          = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (hilo_write_en) begin
        if (hilo_write_sel) hi <= hilo_write_data;
        else                lo <= hilo_write_data;
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mcand  <= op[1] ? abs_2 : abs_1;
            acc_lo <= op[1] ? abs_1 : abs_2;
            acc_hi <= '0;
            cnt    <= CW'(DATA_WIDTH - 1);
            neg_q  <= sign_1 ^ sign_2;
            neg_r  <= sign_1;
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          cnt    <= cnt - 1'b1;
          // Placed after the direct write so the iteration result wins.
          if (last_iter && !flush) begin
            hi <= product_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            lo <= product_fix[DATA_WIDTH-1:0];
          end
        end
        S_DIV: begin
          acc_hi <= rem_nxt;
          acc_lo <= quo_nxt;
          cnt    <= cnt - 1'b1;
          if (last_iter && !flush) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: products, quotients, signed fix-up, divide by
// zero, flush, direct HI/LO writes and reset in the middle of an operation.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_1, operand_2;
  logic        flush;
  logic        hilo_write_en, hilo_write_sel;
  logic [31:0] hilo_write_data;
  logic        stall_request, busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int stalls, done_cyc, dones, seen_done;

  localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

  muldiv_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
    .hilo_write_en(hilo_write_en), .hilo_write_sel(hilo_write_sel),
    .hilo_write_data(hilo_write_data),
    .stall_request(stall_request), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts an operation in cycle 0 and holds start until DONE has been seen.
  // Optionally injects a direct HI/LO write in cycle wr_cyc.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int wr_cyc, input logic wr_sel, input logic [31:0] wr_data,
                        output int n_stall, output int d_cyc, output int n_done);
    n_stall = 0; n_done = 0; d_cyc = -1;
    @(negedge clk);
    start = 1'b1; op = o; operand_1 = a; operand_2 = b;
    for (int c = 0; c < 40; c++) begin
      hilo_write_en   = (c == wr_cyc);
      hilo_write_sel  = wr_sel;
      hilo_write_data = wr_data;
      #1;
      if (stall_request) n_stall++;
      if (done) begin n_done++; d_cyc = c; end
      @(negedge clk);
      if (d_cyc >= 0) break;
    end
    start = 1'b0;
    hilo_write_en = 1'b0;
  endtask

  task automatic direct_write(input logic sel, input logic [31:0] data);
    @(negedge clk);
    hilo_write_en = 1'b1; hilo_write_sel = sel; hilo_write_data = data;
    @(negedge clk);
    hilo_write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_1 = '0; operand_2 = '0; flush = 1'b0;
    hilo_write_en = 1'b0; hilo_write_sel = 1'b0; hilo_write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_stall", {31'b0, stall_request}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    check("multu_stall_cycles", stalls, 33);
    check("multu_done_cycle", done_cyc, 33);
    check("multu_done_count", dones, 1);
    #1;
    check("start_held_no_restart", {31'b0, busy}, 32'h0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("mult_neg3x7_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg3x7_lo", lo, 32'hFFFF_FFEB);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("mult_minsq_hi", hi, 32'h4000_0000);
    check("mult_minsq_lo", lo, 32'h0);

    run_op(OP_DIVU, 32'd100, 32'd7, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("divu_100_7_lo", lo, 32'd14);
    check("divu_100_7_hi", hi, 32'd2);
    check("divu_stall_cycles", stalls, 33);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
    check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("div_7_neg2_lo", lo, 32'hFFFF_FFFD);
    check("div_7_neg2_hi", hi, 32'd1);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("div_overflow_lo", lo, 32'h8000_0000);
    check("div_overflow_hi", hi, 32'h0);

    direct_write(1'b1, 32'h1111_1111);
    direct_write(1'b0, 32'h2222_2222);
    #1;
    check("mthi_preload", hi, 32'h1111_1111);
    check("mtlo_preload", lo, 32'h2222_2222);

    run_op(OP_DIVU, 32'd55, 32'd0, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("divzero_hi", hi, 32'h1111_1111);
    check("divzero_lo", lo, 32'h2222_2222);
    check("divzero_stall_cycles", stalls, 1);
    check("divzero_done_cycle", done_cyc, 1);

    direct_write(1'b0, 32'h0000_ABCD);
    #1;
    check("mtlo_idle", lo, 32'h0000_ABCD);
    check("mtlo_keeps_hi", hi, 32'h1111_1111);

    // Flush a DIVU in cycle 10.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    check("flush_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_after", {31'b0, busy}, 32'h0);
    check("flush_stall_after", {31'b0, stall_request}, 32'h0);
    seen_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) seen_done++;
      @(negedge clk);
      #1;
    end
    check("flush_no_done", seen_done, 0);
    check("flush_hi_kept", hi, 32'h1111_1111);
    check("flush_lo_kept", lo, 32'h0000_ABCD);

    run_op(OP_MULTU, 32'd3, 32'd5, -1, 1'b0, 32'h0, stalls, done_cyc, dones);
    check("after_flush_lo", lo, 32'd15);
    check("after_flush_hi", hi, 32'd0);

    // MTHI coinciding with the final iteration edge.
    run_op(OP_MULTU, 32'h0001_0001, 32'h0003_0000, 32, 1'b1, 32'hDEAD_BEEF, stalls, done_cyc, dones);
    check("mthi_collide_hi", hi, 32'h0000_0003);
    check("mthi_collide_lo", lo, 32'h0003_0000);

    // Reset in cycle 20 of a MULTU.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; operand_1 = 32'd9; operand_2 = 32'd11;
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_stall", {31'b0, stall_request}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
